// File: rtl/mem_if.sv
// Unified instruction/data memory port with a req/ready handshake.
// The core is the master; the memory (or its model) is the slave.
interface mem_if #(
  parameter int XLEN = 64
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV64I-subset core: one ALU, one unified memory port with
// wait states, internal register file, halt/illegal detection.
module multicycle_cpu #(
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32,
  parameter logic [63:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  mem_if.master           mem,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] dbg_pc
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_SD, OP_BEQ
  } op_t;

  state_t          state;
  op_t             op, dec_op;
  logic            dec_ok;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc, oldpc, a, b, imm, aluout, mdr;
  logic [XLEN-1:0] dec_imm, alu_res, br_target;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rf [NREG];

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rs1, rs2, rd;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[15 +: RW];
  assign rs2    = ir[20 +: RW];
  assign rd     = ir[7 +: RW];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  assign dbg_pc = pc;

  always_comb begin
    dec_ok  = 1'b1;
    dec_op  = OP_ADD;
    dec_imm = imm_i;
    case (opcode)
      7'b0110011: begin
        if      (funct7 == 7'b0000000 && funct3 == 3'b000) dec_op = OP_ADD;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_op = OP_SUB;
        else if (funct7 == 7'b0000000 && funct3 == 3'b111) dec_op = OP_AND;
        else if (funct7 == 7'b0000000 && funct3 == 3'b110) dec_op = OP_OR;
        else dec_ok = 1'b0;
      end
      7'b0010011: begin
        dec_op = OP_ADDI;
        dec_ok = (funct3 == 3'b000);
      end
      7'b0000011: begin
        dec_op = OP_LD;
        dec_ok = (funct3 == 3'b011);
      end
      7'b0100011: begin
        dec_op  = OP_SD;
        dec_imm = imm_s;
        dec_ok  = (funct3 == 3'b011);
      end
      7'b1100011: begin
        dec_op  = OP_BEQ;
        dec_imm = imm_b;
        dec_ok  = (funct3 == 3'b000);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Single shared ALU; ld/sd/addi all use A + imm.
  always_comb begin
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      default: alu_res = a + imm;
    endcase
    br_target = (a == b) ? oldpc + imm : pc;
  end

  // Every transition into FETCH/MEM launches the next transfer in the same
  // edge, so a fetch can follow a store completion back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      op        <= OP_ADD;
      pc        <= RESET_PC[XLEN-1:0];
      oldpc     <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      aluout    <= '0;
      mdr       <= '0;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem.req) begin
            mem.req  <= 1'b1;
            mem.we   <= 1'b0;
            mem.addr <= pc;
          end else if (mem.ready) begin
            mem.req <= 1'b0;
            ir      <= mem.rdata[31:0];
            oldpc   <= pc;
            pc      <= pc + XLEN'(4);
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a   <= rf[rs1];
          b   <= rf[rs2];
          imm <= dec_imm;
          op  <= dec_op;
          if (ir == 32'h0000_0073) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (!dec_ok) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          aluout <= alu_res;
          case (op)
            OP_LD, OP_SD: begin
              mem.req   <= 1'b1;
              mem.we    <= (op == OP_SD);
              mem.addr  <= alu_res;
              mem.wdata <= b;
              state     <= S_MEM;
            end
            OP_BEQ: begin
              pc       <= br_target;
              mem.req  <= 1'b1;
              mem.we   <= 1'b0;
              mem.addr <= br_target;
              state    <= S_FETCH;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem.ready) begin
            if (op == OP_LD) begin
              mdr     <= mem.rdata;
              mem.req <= 1'b0;
              state   <= S_WB;
            end else begin
              mem.we   <= 1'b0;
              mem.addr <= pc;
              state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (rd != '0) rf[rd] <= (op == OP_LD) ? mdr : aluout;
          mem.req  <= 1'b1;
          mem.we   <= 1'b0;
          mem.addr <= pc;
          state    <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed programs plus random straight-line
// programs compared against an ISA-level interpreter.
module tb_multicycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_if #(.XLEN(64)) mif ();
  logic        halted, illegal;
  logic [63:0] dbg_pc;
  multicycle_cpu #(.XLEN(64), .NREG(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .mem(mif),
    .halted(halted), .illegal(illegal), .dbg_pc(dbg_pc));

  mem_if #(.XLEN(32)) mif32 ();
  logic        halted32, illegal32;
  logic [31:0] dbg_pc32;
  multicycle_cpu #(.XLEN(32), .NREG(32), .RESET_PC(64'h0)) dut32 (
    .clk(clk), .reset(reset), .mem(mif32),
    .halted(halted32), .illegal(illegal32), .dbg_pc(dbg_pc32));

  int checks = 0, failures = 0;

  function automatic logic [31:0] i_ins(input logic [2:0] f3, input logic [6:0] opc,
                                        input int rd, input int rs1, input int imm);
    logic [31:0] iv, dv, sv;
    iv = imm; dv = rd; sv = rs1;
    return {iv[11:0], sv[4:0], f3, dv[4:0], opc};
  endfunction
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
    logic [31:0] dv, sv, tv;
    dv = rd; sv = rs1; tv = rs2;
    return {f7, tv[4:0], sv[4:0], f3, dv[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] s_ins(input int rs2, input int rs1, input int imm);
    logic [31:0] iv, sv, tv;
    iv = imm; sv = rs1; tv = rs2;
    return {iv[11:5], tv[4:0], sv[4:0], 3'b011, iv[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_ins(input int rs1, input int rs2, input int imm);
    logic [31:0] iv, sv, tv;
    iv = imm; sv = rs1; tv = rs2;
    return {iv[12], iv[10:5], tv[4:0], sv[4:0], 3'b000, iv[4:1], iv[11], 7'h63};
  endfunction
  localparam logic [31:0] ECALL = 32'h0000_0073;

  // 32-bit core runs a fixed ROM with ready tied high.
  function automatic logic [31:0] rom32(input logic [31:0] a);
    case (a)
      32'd0:   return i_ins(3'b000, 7'h13, 1, 0, 5);
      32'd4:   return i_ins(3'b000, 7'h13, 2, 1, -7);
      default: return ECALL;
    endcase
  endfunction
  assign mif32.ready = 1'b1;
  assign mif32.rdata = rom32(mif32.addr);

  // Memory model: img is the program image loaded into mem8 at each reset.
  logic [7:0]  img [1024];
  logic [7:0]  mem8 [1024];
  int          ready_mode = 0, hold_left = 0;
  logic [63:0] hold_addr = '0;
  int          cyc, stalls, we_cyc, wr_cnt, hold_bad, halt_cyc;
  logic [63:0] wr_addr, wr_data;
  logic [63:0] f_pc[$], f_dbg[$];
  int          f_cyc[$];
  logic        prev_stall;
  logic [63:0] p_addr, p_wd;
  logic        p_we;

  always_comb begin
    mif.rdata = '0;
    for (int i = 0; i < 8; i++) mif.rdata[i*8 +: 8] = mem8[(int'(mif.addr[9:0]) + i) & 1023];
  end

  always @(negedge clk) begin
    case (ready_mode)
      0: mif.ready = 1'b1;
      1: mif.ready = ($urandom_range(0, 3) != 0);
      2: mif.ready = !(mif.req && mif.addr >= 64'd256);
      default: begin
        if (mif.req && !mif.we && mif.addr == hold_addr && hold_left > 0) begin
          mif.ready = 1'b0;
          hold_left = hold_left - 1;
        end else mif.ready = 1'b1;
      end
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      cyc <= 0; stalls <= 0; we_cyc <= 0; wr_cnt <= 0; hold_bad <= 0; prev_stall <= 1'b0;
      f_pc.delete(); f_dbg.delete(); f_cyc.delete();
      for (int i = 0; i < 1024; i++) mem8[i] <= img[i];
    end else begin
      cyc        <= cyc + 1;
      prev_stall <= mif.req && !mif.ready;
      p_addr     <= mif.addr;
      p_we       <= mif.we;
      p_wd       <= mif.wdata;
      if (prev_stall && (!mif.req || mif.addr != p_addr || mif.we != p_we || mif.wdata != p_wd))
        hold_bad <= hold_bad + 1;
      if (mif.req && !mif.ready) stalls <= stalls + 1;
      if (mif.req && mif.we) we_cyc <= we_cyc + 1;
      if (mif.req && mif.ready) begin
        if (mif.we) begin
          wr_cnt  <= wr_cnt + 1;
          wr_addr <= mif.addr;
          wr_data <= mif.wdata;
          for (int i = 0; i < 8; i++)
            mem8[(int'(mif.addr[9:0]) + i) & 1023] <= mif.wdata[i*8 +: 8];
        end else if (mif.addr < 64'd256) begin
          f_cyc.push_back(cyc);
          f_pc.push_back(mif.addr);
          f_dbg.push_back(dbg_pc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ISA-level interpreter: architectural effects plus per-instruction cycle cost.
  logic [63:0] m_x [32];
  logic [7:0]  m_mem [1024];
  logic [63:0] exp_pc[$];
  int          exp_lat[$];
  int          m_total;
  logic        m_illegal;

  task automatic model();
    logic [63:0] pc, nx, ea, v, ii, is_, ib;
    logic [31:0] w;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    int          rd, r1, r2, lat;
    bit          done, wr;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = img[i];
    exp_pc.delete(); exp_lat.delete();
    m_total = 1; m_illegal = 1'b0; pc = '0; done = 1'b0;
    for (int s = 0; s < 400 && !done; s++) begin
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = m_mem[(int'(pc[9:0]) + j) & 1023];
      opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      rd = int'(w[11:7]); r1 = int'(w[19:15]); r2 = int'(w[24:20]);
      ii  = 64'(signed'(w[31:20]));
      is_ = 64'(signed'({w[31:25], w[11:7]}));
      ib  = 64'(signed'({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      exp_pc.push_back(pc);
      nx = pc + 64'd4; lat = 4; wr = 1'b0; v = '0;
      if (w == ECALL) begin
        lat = 2; done = 1'b1;
      end else if (opc == 7'h13 && f3 == 3'd0) begin
        v = m_x[r1] + ii; wr = 1'b1;
      end else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin
        v = m_x[r1] + m_x[r2]; wr = 1'b1;
      end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
        v = m_x[r1] - m_x[r2]; wr = 1'b1;
      end else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin
        v = m_x[r1] & m_x[r2]; wr = 1'b1;
      end else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin
        v = m_x[r1] | m_x[r2]; wr = 1'b1;
      end else if (opc == 7'h03 && f3 == 3'd3) begin
        ea = m_x[r1] + ii;
        for (int j = 0; j < 8; j++) v[j*8 +: 8] = m_mem[(int'(ea[9:0]) + j) & 1023];
        wr = 1'b1; lat = 5;
      end else if (opc == 7'h23 && f3 == 3'd3) begin
        ea = m_x[r1] + is_;
        for (int j = 0; j < 8; j++) m_mem[(int'(ea[9:0]) + j) & 1023] = m_x[r2][j*8 +: 8];
      end else if (opc == 7'h63 && f3 == 3'd0) begin
        if (m_x[r1] == m_x[r2]) nx = pc + ib;
        lat = 3;
      end else begin
        lat = 2; done = 1'b1; m_illegal = 1'b1;
      end
      if (wr && rd != 0) m_x[rd] = v;
      m_total += lat;
      exp_lat.push_back(lat);
      pc = nx;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 8'h00;
  endtask
  task automatic put(input int addr, input logic [31:0] w);
    for (int j = 0; j < 4; j++) img[addr + j] = w[j*8 +: 8];
  endtask

  task automatic run(input int mode, input int budget);
    ready_mode = mode;
    halt_cyc = -1;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (halted) begin
        halt_cyc = cyc;
        break;
      end
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  task automatic check_run(input string tag, input bit timing);
    logic [63:0] dv, mv;
    int n;
    model();
    chk({tag, "_illegal"}, illegal, m_illegal);
    chk({tag, "_nfetch"}, f_pc.size(), exp_pc.size());
    n = (f_pc.size() < exp_pc.size()) ? f_pc.size() : exp_pc.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_fpc%0d", tag, k), f_pc[k], exp_pc[k]);
      chk($sformatf("%s_dbgpc%0d", tag, k), f_dbg[k], exp_pc[k]);
      if (timing && k < n - 1)
        chk($sformatf("%s_lat%0d", tag, k), f_cyc[k+1] - f_cyc[k], exp_lat[k]);
    end
    chk({tag, "_cycles"}, halt_cyc, m_total + stalls);
    chk({tag, "_hold"}, hold_bad, 0);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_x%0d", tag, i), dut.rf[i], m_x[i]);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        dv[j*8 +: 8] = mem8[256 + 8*k + j];
        mv[j*8 +: 8] = m_mem[256 + 8*k + j];
      end
      chk($sformatf("%s_mem%0d", tag, k), dv, mv);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_req_after_halt"}, mif.req, 1'b0);
    chk({tag, "_still_halted"}, halted, 1'b1);
  endtask

  initial begin
    clear_img();
    repeat (2) @(negedge clk);
    chk("rst_req", mif.req, 1'b0);
    chk("rst_we", mif.we, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_dbg_pc", dbg_pc, 64'h0);
    chk("rst_x5", dut.rf[5], 64'h0);

    // addi/addi then sd/ld round trip
    clear_img();
    put(0,  i_ins(3'b000, 7'h13, 1, 0, 5));
    put(4,  i_ins(3'b000, 7'h13, 2, 1, -7));
    put(8,  s_ins(2, 0, 256));
    put(12, i_ins(3'b011, 7'h03, 3, 0, 256));
    put(16, ECALL);
    run(0, 100);
    check_run("s1", 1'b1);
    chk("s1_x1", dut.rf[1], 64'd5);
    chk("s1_x2", dut.rf[2], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("s1_x3", dut.rf[3], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("s1_two_addi_cycles", f_cyc[2] - f_cyc[0], 8);
    chk("s1_wr_addr", wr_addr, 64'd256);
    chk("s1_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("s1_wr_cnt", wr_cnt, 1);
    chk("s1_we_cycles", we_cyc, 1);
    chk("x32_x1", dut32.rf[1], 32'd5);
    chk("x32_x2", dut32.rf[2], 32'hFFFF_FFFE);
    chk("x32_halted", halted32, 1'b1);
    chk("x32_illegal", illegal32, 1'b0);

    // three wait cycles on the second fetch
    hold_addr = 64'd4;
    hold_left = 3;
    run(3, 100);
    check_run("hold", 1'b0);
    chk("hold_stalls", stalls, 3);
    chk("hold_instr_cycles", f_cyc[1] - f_cyc[0], 7);

    // beq taken once back to 4, then falls through to 12
    clear_img();
    put(0,  i_ins(3'b000, 7'h13, 2, 0, 1));
    put(4,  i_ins(3'b000, 7'h13, 1, 1, 1));
    put(8,  b_ins(1, 2, -4));
    put(12, ECALL);
    run(0, 100);
    check_run("beq", 1'b1);
    chk("beq_taken_pc", f_pc[3], 64'd4);
    chk("beq_fall_pc", f_pc[5], 64'd12);

    // x0 write ignored, then an all-ones word
    clear_img();
    put(0, i_ins(3'b000, 7'h13, 1, 0, 3));
    put(4, r_ins(7'h00, 3'b000, 0, 1, 1));
    put(8, 32'hFFFF_FFFF);
    run(0, 100);
    check_run("ill", 1'b1);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_x0", dut.rf[0], 64'h0);

    // unsupported funct3 on an R-type
    clear_img();
    put(0, r_ins(7'h20, 3'b001, 3, 1, 2));
    run(0, 100);
    check_run("badfunct", 1'b1);

    // random straight-line programs, ready high then random stalls
    for (int r = 0; r < 2; r++) begin
      clear_img();
      for (int i = 256; i < 320; i++) img[i] = 8'($urandom);
      for (int k = 0; k < 24; k++) begin
        int t, rd, r1, r2, off;
        logic [31:0] w;
        t = $urandom_range(0, 6);
        rd = $urandom_range(0, 7); r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7);
        off = 256 + 8 * $urandom_range(0, 7);
        case (t)
          0: w = i_ins(3'b000, 7'h13, rd, r1, int'($urandom_range(0, 4095)) - 2048);
          1: w = r_ins(7'h00, 3'b000, rd, r1, r2);
          2: w = r_ins(7'h20, 3'b000, rd, r1, r2);
          3: w = r_ins(7'h00, 3'b111, rd, r1, r2);
          4: w = r_ins(7'h00, 3'b110, rd, r1, r2);
          5: w = s_ins(r2, 0, off);
          default: w = i_ins(3'b011, 7'h03, rd, 0, off);
        endcase
        put(4 * k, w);
      end
      put(96, ECALL);
      run(r, 500);
      check_run($sformatf("rnd%0d", r), (r == 0));
    end

    // reset while a load is stuck waiting in MEM
    clear_img();
    put(0, i_ins(3'b000, 7'h13, 1, 0, 9));
    put(4, i_ins(3'b011, 7'h03, 2, 0, 256));
    put(8, ECALL);
    ready_mode = 2;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mif.req && mif.addr == 64'd256) break;
    end
    repeat (2) @(negedge clk);
    chk("mrst_req_held", mif.req, 1'b1);
    chk("mrst_addr_held", mif.addr, 64'd256);
    chk("mrst_we", mif.we, 1'b0);
    chk("mrst_x1_before", dut.rf[1], 64'd9);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_req", mif.req, 1'b0);
    chk("mrst_pc", dbg_pc, 64'h0);
    chk("mrst_x1", dut.rf[1], 64'h0);
    chk("mrst_halted", halted, 1'b0);
    ready_mode = 0;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_refetch_req", mif.req, 1'b1);
    chk("mrst_refetch_addr", mif.addr, 64'h0);
    chk("mrst_refetch_we", mif.we, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
